// File: rtl/cachepool_l2_refill_sched_if.sv
// Request/channel/response bundle for the L2 refill scheduler.
// Statistics signals exist only when CACHEPOOL_L2_SCHED_STATS_EN is defined.
// slave: the scheduler's view. master: the requesters and L2 channels around it.
interface cachepool_l2_refill_sched_if #(
  parameter int unsigned NumReq    = 5,
  parameter int unsigned NumChan   = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned PldWidth  = 300,
  parameter int unsigned RspWidth  = 140
);
  localparam int unsigned IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [NumReq-1:0]           req_valid_i;
  logic [NumReq-1:0]           req_ready_o;
  logic [NumReq*AddrWidth-1:0] req_addr_i;
  logic [NumReq*PldWidth-1:0]  req_pld_i;
  logic [NumChan-1:0]          chan_valid_o;
  logic [NumChan-1:0]          chan_ready_i;
  logic [NumChan*AddrWidth-1:0] chan_addr_o;
  logic [NumChan*PldWidth-1:0] chan_pld_o;
  logic [NumChan*IdWidth-1:0]  chan_id_o;
  logic [NumChan-1:0]          rsp_valid_i;
  logic [NumChan-1:0]          rsp_ready_o;
  logic [NumChan*IdWidth-1:0]  rsp_id_i;
  logic [NumChan*RspWidth-1:0] rsp_pld_i;
  logic [NumReq-1:0]           out_rsp_valid_o;
  logic [NumReq-1:0]           out_rsp_ready_i;
  logic [NumReq*RspWidth-1:0]  out_rsp_pld_o;
`ifdef CACHEPOOL_L2_SCHED_STATS_EN
  logic [NumChan*32-1:0]       stat_grant_o;
  logic [NumChan*32-1:0]       stat_conflict_o;
  logic [NumChan*32-1:0]       stat_stall_o;
`else
  // Statistics signals are not present in this configuration.
`endif

  modport slave (
    input  req_valid_i, req_addr_i, req_pld_i, chan_ready_i,
    input  rsp_valid_i, rsp_id_i, rsp_pld_i, out_rsp_ready_i,
    output req_ready_o, chan_valid_o, chan_addr_o, chan_pld_o, chan_id_o,
    output rsp_ready_o, out_rsp_valid_o, out_rsp_pld_o
`ifdef CACHEPOOL_L2_SCHED_STATS_EN
    , output stat_grant_o, stat_conflict_o, stat_stall_o
`endif
  );

  modport master (
    output req_valid_i, req_addr_i, req_pld_i, chan_ready_i,
    output rsp_valid_i, rsp_id_i, rsp_pld_i, out_rsp_ready_i,
    input  req_ready_o, chan_valid_o, chan_addr_o, chan_pld_o, chan_id_o,
    input  rsp_ready_o, out_rsp_valid_o, out_rsp_pld_o
`ifdef CACHEPOOL_L2_SCHED_STATS_EN
    , input stat_grant_o, stat_conflict_o, stat_stall_o
`endif
  );
endinterface

// File: rtl/cachepool_l2_refill_sched.sv
// L2 refill scheduler: routes requester refills to interleaved L2 channels through
// per-channel round-robin arbiters and registered output stages, limits outstanding
// transactions per requester and routes responses back round-robin per requester.
// Optional per-channel statistics: define CACHEPOOL_L2_SCHED_STATS_EN.

// Outstanding-counter underflow checker.
module cachepool_l2_refill_sched_chk #(
  parameter int unsigned NumReq = 5
) (
  input logic              clk_i,
  input logic              rst_i,
  input logic [NumReq-1:0] underflow_i
);
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) underflow_i == '0);
endmodule

module cachepool_l2_refill_sched #(
  parameter int unsigned NumReq     = 5,
  parameter int unsigned NumChan    = 4,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned PldWidth   = 300,
  parameter int unsigned RspWidth   = 140,
  parameter int unsigned ChanSelLsb = 14,
  parameter int unsigned MaxOutst   = 32
) (
  input logic                        clk_i,
  input logic                        rst_i,
  cachepool_l2_refill_sched_if.slave bus
);
  localparam int unsigned IdWidth  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned ChWidth  = $clog2(NumChan);
  localparam int unsigned CntWidth = $clog2(MaxOutst + 1);

  logic [NumChan-1:0]   stage_valid_r;
  logic [AddrWidth-1:0] stage_addr_r [NumChan];
  logic [PldWidth-1:0]  stage_pld_r  [NumChan];
  logic [IdWidth-1:0]   stage_id_r   [NumChan];
  logic [IdWidth-1:0]   req_ptr_r    [NumChan];
  logic [ChWidth-1:0]   rsp_ptr_r    [NumReq];
  logic [CntWidth-1:0]  cnt_r        [NumReq];

  logic [NumReq-1:0]          elig_s [NumChan];
  logic [IdWidth-1:0]         win_s  [NumChan];
  logic [NumChan-1:0]         grant_s;
  logic [NumChan-1:0]         load_s;
  logic [NumReq-1:0]          req_ready_s;
  logic [NumReq-1:0]          req_hs_s;
  logic [NumReq-1:0]          out_valid_s;
  logic [NumReq-1:0]          out_hs_s;
  logic [ChWidth-1:0]         rsp_pick_s [NumReq];
  logic [NumChan-1:0]         rsp_ready_s;
  logic [NumReq*RspWidth-1:0] out_pld_s;
  logic [NumReq-1:0]          underflow_s;

  // Response routing: each requester picks round-robin among channels returning to it.
  always_comb begin
    logic               hit_s;
    logic [ChWidth-1:0] ch_s;
    out_valid_s = '0;
    out_hs_s    = '0;
    rsp_ready_s = '0;
    out_pld_s   = '0;
    for (int r = 0; r < NumReq; r++) begin
      rsp_pick_s[r] = '0;
      hit_s         = 1'b0;
      for (int k = 0; k < NumChan; k++) begin
        ch_s = rsp_ptr_r[r] + ChWidth'(k);
        if (!hit_s && bus.rsp_valid_i[ch_s]
            && (bus.rsp_id_i[ch_s*IdWidth +: IdWidth] == IdWidth'(r))) begin
          hit_s         = 1'b1;
          rsp_pick_s[r] = ch_s;
        end else begin
          rsp_pick_s[r] = rsp_pick_s[r];
        end
      end
      out_valid_s[r] = hit_s && !rst_i;
      out_hs_s[r]    = out_valid_s[r] && bus.out_rsp_ready_i[r];
      out_pld_s[r*RspWidth +: RspWidth] = bus.rsp_pld_i[rsp_pick_s[r]*RspWidth +: RspWidth];
      rsp_ready_s = rsp_ready_s | (out_hs_s[r] ? (NumChan'(1) << rsp_pick_s[r]) : NumChan'(0));
    end
  end

  // Eligibility and per-channel round-robin grant. A response completing this cycle frees
  // a slot immediately, so a requester at its limit may still be granted in that cycle.
  always_comb begin
    logic found_s;
    int   idx_s;
    grant_s     = '0;
    load_s      = '0;
    req_ready_s = '0;
    for (int c = 0; c < NumChan; c++) begin
      elig_s[c] = '0;
      win_s[c]  = '0;
      found_s   = 1'b0;
      load_s[c] = !stage_valid_r[c] || bus.chan_ready_i[c];
      for (int r = 0; r < NumReq; r++) begin
        elig_s[c][r] = bus.req_valid_i[r]
                       && (bus.req_addr_i[r*AddrWidth + ChanSelLsb +: ChWidth] == ChWidth'(c))
                       && ((cnt_r[r] < CntWidth'(MaxOutst)) || out_hs_s[r]);
      end
      for (int k = 0; k < NumReq; k++) begin
        idx_s = (int'(req_ptr_r[c]) + k) % int'(NumReq);
        if (!found_s && elig_s[c][idx_s]) begin
          found_s  = 1'b1;
          win_s[c] = IdWidth'(idx_s);
        end else begin
          win_s[c] = win_s[c];
        end
      end
      grant_s[c]  = found_s && load_s[c] && !rst_i;
      req_ready_s = req_ready_s | (grant_s[c] ? (NumReq'(1) << win_s[c]) : NumReq'(0));
    end
    req_hs_s = bus.req_valid_i & req_ready_s;
  end

  // Channel output stages and request round-robin pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_valid_r <= '0;
      for (int c = 0; c < NumChan; c++) begin
        stage_addr_r[c] <= '0;
        stage_pld_r[c]  <= '0;
        stage_id_r[c]   <= '0;
        req_ptr_r[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NumChan; c++) begin
        if (load_s[c]) begin
          stage_valid_r[c] <= grant_s[c];
          if (grant_s[c]) begin
            stage_addr_r[c] <= bus.req_addr_i[win_s[c]*AddrWidth +: AddrWidth];
            stage_pld_r[c]  <= bus.req_pld_i[win_s[c]*PldWidth +: PldWidth];
            stage_id_r[c]   <= win_s[c];
            req_ptr_r[c]    <= (win_s[c] == IdWidth'(NumReq - 1)) ? IdWidth'(0)
                                                                   : win_s[c] + IdWidth'(1);
          end
        end
      end
    end
  end

  // Outstanding counters and response pointers; a return with nothing outstanding holds at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NumReq; r++) begin
        cnt_r[r]     <= '0;
        rsp_ptr_r[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NumReq; r++) begin
        case ({req_hs_s[r], out_hs_s[r]})
          2'b10:   cnt_r[r] <= cnt_r[r] + CntWidth'(1);
          2'b01:   cnt_r[r] <= (cnt_r[r] == '0) ? '0 : cnt_r[r] - CntWidth'(1);
          default: cnt_r[r] <= cnt_r[r];
        endcase
        if (out_hs_s[r]) begin
          rsp_ptr_r[r] <= rsp_pick_s[r] + ChWidth'(1);
        end
      end
    end
  end

  // Flags a response handshake for a requester with nothing outstanding.
  always_comb begin
    underflow_s = '0;
    for (int r = 0; r < NumReq; r++) begin
      underflow_s[r] = out_hs_s[r] && (cnt_r[r] == '0);
    end
  end

  cachepool_l2_refill_sched_chk #(.NumReq(NumReq)) u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .underflow_i (underflow_s)
  );

  assign bus.req_ready_o     = req_ready_s;
  assign bus.chan_valid_o    = stage_valid_r;
  assign bus.rsp_ready_o     = rsp_ready_s;
  assign bus.out_rsp_valid_o = out_valid_s;
  assign bus.out_rsp_pld_o   = out_pld_s;

  for (genvar c = 0; c < NumChan; c++) begin : g_chan_out
    assign bus.chan_addr_o[c*AddrWidth +: AddrWidth] = stage_addr_r[c];
    assign bus.chan_pld_o[c*PldWidth +: PldWidth]    = stage_pld_r[c];
    assign bus.chan_id_o[c*IdWidth +: IdWidth]       = stage_id_r[c];
  end

`ifdef CACHEPOOL_L2_SCHED_STATS_EN
  logic [31:0] stat_grant_r    [NumChan];
  logic [31:0] stat_conflict_r [NumChan];
  logic [31:0] stat_stall_r    [NumChan];

  // Saturating per-channel grant, conflict and stall counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NumChan; c++) begin
        stat_grant_r[c]    <= '0;
        stat_conflict_r[c] <= '0;
        stat_stall_r[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NumChan; c++) begin
        if (grant_s[c] && (stat_grant_r[c] != 32'hFFFF_FFFF)) begin
          stat_grant_r[c] <= stat_grant_r[c] + 32'd1;
        end
        if (($countones(elig_s[c]) > 1) && (stat_conflict_r[c] != 32'hFFFF_FFFF)) begin
          stat_conflict_r[c] <= stat_conflict_r[c] + 32'd1;
        end
        if (stage_valid_r[c] && !bus.chan_ready_i[c] && (stat_stall_r[c] != 32'hFFFF_FFFF)) begin
          stat_stall_r[c] <= stat_stall_r[c] + 32'd1;
        end
      end
    end
  end

  for (genvar c = 0; c < NumChan; c++) begin : g_stat_out
    assign bus.stat_grant_o[c*32 +: 32]    = stat_grant_r[c];
    assign bus.stat_conflict_o[c*32 +: 32] = stat_conflict_r[c];
    assign bus.stat_stall_o[c*32 +: 32]    = stat_stall_r[c];
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cachepool_l2_refill_sched.sv
// Directed bench for cachepool_l2_refill_sched (MaxOutst reduced to 4).
module tb_cachepool_l2_refill_sched;
  localparam int NR = 5;
  localparam int NC = 4;
  localparam int AW = 32;
  localparam int PW = 300;
  localparam int RW = 140;
  localparam int IW = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  cachepool_l2_refill_sched_if #(.NumReq(NR), .NumChan(NC), .AddrWidth(AW),
                                 .PldWidth(PW), .RspWidth(RW)) bus ();

  cachepool_l2_refill_sched #(.NumReq(NR), .NumChan(NC), .AddrWidth(AW), .PldWidth(PW),
                              .RspWidth(RW), .ChanSelLsb(14), .MaxOutst(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          r;
    logic [31:0] addr;
    int          ch;
    logic [4:0]  exp_ready;
    logic [3:0]  exp_cv;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pld_of(input int r, input int i);
    logic [PW-1:0] p;
    p = '0;
    p[299:288] = 12'hA00 | 12'(r);
    p[160 +: 16] = 16'(i) ^ 16'h5A5A;
    p[31:0] = 32'hC0DE_0000 + 32'(i);
    return p;
  endfunction

  function automatic logic [RW-1:0] rsp_of(input int i);
    logic [RW-1:0] p;
    p = '0;
    p[139:128] = 12'hB00 | 12'(i);
    p[63:0] = 64'h1234_5678_0000_0000 | 64'(i);
    return p;
  endfunction

  task automatic clear_inputs();
    bus.req_valid_i     = '0;
    bus.req_addr_i      = '0;
    bus.req_pld_i       = '0;
    bus.chan_ready_i    = '1;
    bus.rsp_valid_i     = '0;
    bus.rsp_id_i        = '0;
    bus.rsp_pld_i       = '0;
    bus.out_rsp_ready_i = '1;
  endtask

  task automatic set_req(input int r, input logic [31:0] addr, input logic [PW-1:0] pld);
    bus.req_valid_i[r] = 1'b1;
    bus.req_addr_i[r*AW +: AW] = addr;
    bus.req_pld_i[r*PW +: PW] = pld;
  endtask

  task automatic set_rsp(input int c, input int id, input logic [RW-1:0] pld);
    bus.rsp_valid_i[c] = 1'b1;
    bus.rsp_id_i[c*IW +: IW] = IW'(id);
    bus.rsp_pld_i[c*RW +: RW] = pld;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    int acc;
    vecs[0] = '{0, 32'h8000_4000, 1, 5'b00001, 4'b0010};
    vecs[1] = '{1, 32'h0000_0000, 0, 5'b00010, 4'b0001};
    vecs[2] = '{2, 32'h1234_8ABC, 2, 5'b00100, 4'b0100};
    vecs[3] = '{3, 32'hFFFF_FFFF, 3, 5'b01000, 4'b1000};
    vecs[4] = '{4, 32'h0000_C010, 3, 5'b10000, 4'b1000};
    vecs[5] = '{4, 32'h0001_3FFF, 0, 5'b10000, 4'b0001};
    vecs[6] = '{2, 32'h0000_7FFF, 1, 5'b00100, 4'b0010};

    // Reset state, with requests and responses offered during reset.
    clear_inputs();
    set_req(0, 32'h0000_4000, pld_of(0, 1));
    set_rsp(1, 0, rsp_of(1));
    @(negedge clk_i);
    check("rst_req_ready", bus.req_ready_o, 5'b00000);
    check("rst_rsp_ready", bus.rsp_ready_o, 4'b0000);
    tick();
    tick();
    clear_inputs();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_chan_valid", bus.chan_valid_o, 4'b0000);
    check("rst_chan_addr", bus.chan_addr_o, 128'h0);
    check("rst_chan_id", bus.chan_id_o, 12'h0);
    tick();

    // Single-request vectors: select, forward, return.
    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      set_req(vecs[i].r, vecs[i].addr, pld_of(vecs[i].r, i));
      @(negedge clk_i);
      check("vec_req_ready", bus.req_ready_o, vecs[i].exp_ready);
      tick();
      bus.req_valid_i = '0;
      check("vec_chan_valid", bus.chan_valid_o, vecs[i].exp_cv);
      check("vec_chan_addr", bus.chan_addr_o[vecs[i].ch*AW +: AW], vecs[i].addr);
      check("vec_chan_id", bus.chan_id_o[vecs[i].ch*IW +: IW], vecs[i].r);
      check("vec_chan_pld", bus.chan_pld_o[vecs[i].ch*PW +: PW], pld_of(vecs[i].r, i));
      set_rsp(vecs[i].ch, vecs[i].r, rsp_of(i));
      @(negedge clk_i);
      check("vec_out_valid", bus.out_rsp_valid_o, vecs[i].exp_ready);
      check("vec_out_pld", bus.out_rsp_pld_o[vecs[i].r*RW +: RW], rsp_of(i));
      check("vec_rsp_ready", bus.rsp_ready_o, vecs[i].exp_cv);
      tick();
      clear_inputs();
      check("vec_cnt_zero", dut.cnt_r[vecs[i].r], 0);
      check("vec_drained", bus.chan_valid_o, 4'b0000);
    end

    // Conflict: r0..r3 all on channel 2.
    do_reset();
    for (int r = 0; r < 4; r++) set_req(r, 32'h0000_8000 | 32'(r << 4), pld_of(r, 100));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      check("conflict_grant", bus.req_ready_o, 5'(1) << (k % 4));
      tick();
      check("conflict_id", bus.chan_id_o[2*IW +: IW], k % 4);
      check("conflict_valid", bus.chan_valid_o, 4'b0100);
    end
    clear_inputs();
`ifdef CACHEPOOL_L2_SCHED_STATS_EN
    check("stat_conflict", bus.stat_conflict_o[2*32 +: 32], 8);
    check("stat_grant", bus.stat_grant_o[2*32 +: 32], 8);
`endif

    // Backpressure on channel 0.
    do_reset();
    bus.chan_ready_i = 4'b1110;
    set_req(0, 32'h0000_0100, pld_of(0, 200));
    @(negedge clk_i);
    check("bp_first_ready", bus.req_ready_o, 5'b00001);
    tick();
    bus.req_valid_i = '0;
    set_req(1, 32'h0000_0200, pld_of(1, 201));
    set_req(2, 32'h0000_0300, pld_of(2, 202));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("bp_ready_low", bus.req_ready_o, 5'b00000);
      check("bp_valid_held", bus.chan_valid_o, 4'b0001);
      check("bp_addr_held", bus.chan_addr_o[0 +: AW], 32'h0000_0100);
      check("bp_pld_held", bus.chan_pld_o[0 +: PW], pld_of(0, 200));
      tick();
    end
    bus.chan_ready_i = 4'b1111;
    @(negedge clk_i);
    check("bp_resume_r1", bus.req_ready_o, 5'b00010);
    tick();
    bus.req_valid_i[1] = 1'b0;
    check("bp_addr_r1", bus.chan_addr_o[0 +: AW], 32'h0000_0200);
    @(negedge clk_i);
    check("bp_resume_r2", bus.req_ready_o, 5'b00100);
    tick();
    bus.req_valid_i[2] = 1'b0;
    check("bp_addr_r2", bus.chan_addr_o[0 +: AW], 32'h0000_0300);
    check("bp_valid_r2", bus.chan_valid_o, 4'b0001);

    // Outstanding limit of 4 for r1, then a same-cycle return frees a slot.
    do_reset();
    set_req(1, 32'h0000_4000, pld_of(1, 300));
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (bus.req_ready_o[1]) acc++;
      tick();
    end
    check("outst_accepted", acc, 4);
    set_rsp(1, 1, rsp_of(300));
    @(negedge clk_i);
    check("outst_bypass_ready", bus.req_ready_o, 5'b00010);
    check("outst_rsp_valid", bus.out_rsp_valid_o, 5'b00010);
    tick();
    clear_inputs();
    check("outst_cnt_hold", dut.cnt_r[1], 4);

    // Simultaneous accept and return for r2.
    do_reset();
    set_req(2, 32'h0000_0000, pld_of(2, 400));
    @(negedge clk_i);
    check("simul_first_ready", bus.req_ready_o, 5'b00100);
    tick();
    check("simul_cnt_one", dut.cnt_r[2], 1);
    set_rsp(3, 2, rsp_of(401));
    @(negedge clk_i);
    check("simul_req_ready", bus.req_ready_o, 5'b00100);
    check("simul_rsp_ready", bus.rsp_ready_o, 4'b1000);
    tick();
    clear_inputs();
    check("simul_cnt_same", dut.cnt_r[2], 1);
    set_rsp(3, 2, rsp_of(402));
    @(negedge clk_i);
    check("simul_last_rsp", bus.out_rsp_valid_o, 5'b00100);
    tick();
    clear_inputs();
    check("simul_cnt_zero", dut.cnt_r[2], 0);

    // Response contention: channels 0 and 3 both return to r4.
    do_reset();
    set_req(4, 32'h0000_0000, pld_of(4, 500));
    for (int k = 0; k < 4; k++) tick();
    clear_inputs();
    check("cont_cnt_full", dut.cnt_r[4], 4);
    set_rsp(0, 4, rsp_of(510));
    set_rsp(3, 4, rsp_of(513));
    bus.out_rsp_ready_i = 5'b01111;
    @(negedge clk_i);
    check("cont_stall_rsp_ready", bus.rsp_ready_o, 4'b0000);
    check("cont_stall_valid", bus.out_rsp_valid_o, 5'b10000);
    check("cont_stall_pld", bus.out_rsp_pld_o[4*RW +: RW], rsp_of(510));
    tick();
    bus.out_rsp_ready_i = 5'b11111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("cont_rsp_ready", bus.rsp_ready_o, (k % 2 == 0) ? 4'b0001 : 4'b1000);
      check("cont_pld", bus.out_rsp_pld_o[4*RW +: RW], (k % 2 == 0) ? rsp_of(510) : rsp_of(513));
      tick();
    end
    clear_inputs();
    check("cont_cnt_zero", dut.cnt_r[4], 0);

    // Reset with three channels busy.
    do_reset();
    bus.chan_ready_i = 4'b0000;
    set_req(0, 32'h0000_0000, pld_of(0, 600));
    set_req(1, 32'h0000_4000, pld_of(1, 601));
    set_req(2, 32'h0000_8000, pld_of(2, 602));
    @(negedge clk_i);
    check("mid_par_ready", bus.req_ready_o, 5'b00111);
    tick();
    check("mid_busy", bus.chan_valid_o, 4'b0111);
    rst_i = 1'b1;
    set_rsp(0, 0, rsp_of(603));
    @(negedge clk_i);
    check("mid_rst_req_ready", bus.req_ready_o, 5'b00000);
    check("mid_rst_rsp_ready", bus.rsp_ready_o, 4'b0000);
    tick();
    check("mid_valid_clear", bus.chan_valid_o, 4'b0000);
    check("mid_addr_clear", bus.chan_addr_o, 128'h0);
    check("mid_cnt0", dut.cnt_r[0], 0);
    check("mid_cnt1", dut.cnt_r[1], 0);
    check("mid_cnt2", dut.cnt_r[2], 0);
    clear_inputs();
    rst_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
